// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   SZ_*  : request size codes (byte, half, word, dword)
//   ERR_* : response error codes (ok, misaligned, timeout)
//   state_t : control FSM states
package lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
//   size      in  2       access size code (1 << size bytes)
//   off       in  log2NB  byte offset inside the memory word
//   sgn       in  1       sign-extend loads
//   wdata     in  DATA_W  right-justified store data
//   rdata     in  DATA_W  memory read data, little-endian lanes
//   be        out NB      byte enables for the access
//   wdata_rep out DATA_W  store data replicated at every size-aligned slot
//   rdata_ext out DATA_W  extracted and extended load data
//   misal     out 1       access not naturally aligned or wider than the bus
module lsu_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                    size,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic                          sgn,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W-1:0]             rdata,
    output logic [DATA_W/8-1:0]           be,
    output logic [DATA_W-1:0]             wdata_rep,
    output logic [DATA_W-1:0]             rdata_ext,
    output logic                          misal
);
    localparam int NB = DATA_W / 8;

    int nb;
    int eb;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] sh;
    logic              sbit;

    always_comb begin
        nb = 1 << size;
        // eb clamps an illegal dword on a 32-bit bus to the bus width so shifts stay sane
        eb = nb > NB ? NB : nb;
        misal = (nb > NB) || ((int'(off) & (nb - 1)) != 0);
        be = NB'(((1 << eb) - 1) << off);
        // shifting by DATA_W yields zero, so full-width accesses keep every bit
        keep = ~({DATA_W{1'b1}} << (8 * eb));
        lo = wdata & keep;
        wdata_rep = '0;
        for (int k = 0; k < NB; k++)
            wdata_rep = wdata_rep | (((k & (eb - 1)) == 0) ? lo << (8 * k) : '0);
        sh = rdata >> {off, 3'b000};
        sbit = |(sh & ({{(DATA_W-1){1'b0}}, 1'b1} << (8 * eb - 1)));
        rdata_ext = (sh & keep) | ({DATA_W{sgn & sbit}} & ~keep);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between execute and write-back.
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/ready/write/size/signed/addr/wdata/rd   request handshake from execute
//   mem_req/we/addr/wdata/be, mem_ack/rdata           ready/ack data-memory port
//   rsp_valid/ready/data/rd/err                       response handshake to write-back
// Every output except req_ready is registered; req_ready is high only while idle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [4:0]            rsp_rd,
    output logic [1:0]            rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t state, n_state;
    logic [CW-1:0]     cnt, n_cnt;
    logic              l_we, n_l_we;
    logic              l_sgn, n_l_sgn;
    logic [1:0]        l_size, n_l_size;
    logic [OW-1:0]     l_off, n_l_off;
    logic              n_mem_req, n_mem_we;
    logic [ADDR_W-1:0] n_mem_addr;
    logic [DATA_W-1:0] n_mem_wdata;
    logic [NB-1:0]     n_mem_be;
    logic              n_rsp_valid;
    logic [DATA_W-1:0] n_rsp_data;
    logic [4:0]        n_rsp_rd;
    logic [1:0]        n_rsp_err;

    logic              idle;
    logic [1:0]        a_size;
    logic [OW-1:0]     a_off;
    logic              a_sgn;
    logic [NB-1:0]     a_be;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_misal;

    assign idle      = state == S_IDLE;
    assign req_ready = idle;
    // While idle the aligner sees the incoming request; afterwards the latched one,
    // so load extraction at ack time uses the accepted size/offset/sign.
    assign a_size    = idle ? req_size : l_size;
    assign a_off     = idle ? req_addr[OW-1:0] : l_off;
    assign a_sgn     = idle ? req_signed : l_sgn;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .size      (a_size),
        .off       (a_off),
        .sgn       (a_sgn),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_rep (a_wdata),
        .rdata_ext (a_rdata),
        .misal     (a_misal)
    );

    always_comb begin
        n_state     = state;
        n_cnt       = cnt;
        n_l_we      = l_we;
        n_l_sgn     = l_sgn;
        n_l_size    = l_size;
        n_l_off     = l_off;
        n_mem_req   = mem_req;
        n_mem_we    = mem_we;
        n_mem_addr  = mem_addr;
        n_mem_wdata = mem_wdata;
        n_mem_be    = mem_be;
        n_rsp_valid = rsp_valid;
        n_rsp_data  = rsp_data;
        n_rsp_rd    = rsp_rd;
        n_rsp_err   = rsp_err;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    n_l_we   = req_write;
                    n_l_sgn  = req_signed;
                    n_l_size = req_size;
                    n_l_off  = req_addr[OW-1:0];
                    n_rsp_rd = req_rd;
                    if (a_misal) begin
                        n_state     = S_RESP;
                        n_rsp_valid = 1'b1;
                        n_rsp_err   = ERR_MISAL;
                        n_rsp_data  = '0;
                    end else begin
                        n_state     = S_ACCESS;
                        n_cnt       = '0;
                        n_mem_req   = 1'b1;
                        n_mem_we    = req_write;
                        n_mem_addr  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        n_mem_be    = a_be;
                        n_mem_wdata = a_wdata;
                    end
                end
            end
            S_ACCESS: begin
                // ack is tested first so an ack on the limit cycle still succeeds
                if (mem_ack) begin
                    n_state     = S_RESP;
                    n_mem_req   = 1'b0;
                    n_rsp_valid = 1'b1;
                    n_rsp_err   = ERR_OK;
                    n_rsp_data  = l_we ? '0 : a_rdata;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    n_state     = S_RESP;
                    n_mem_req   = 1'b0;
                    n_rsp_valid = 1'b1;
                    n_rsp_err   = ERR_TMO;
                    n_rsp_data  = '0;
                end else begin
                    n_cnt = cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    n_state     = S_IDLE;
                    n_rsp_valid = 1'b0;
                end
            end
            default: n_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            l_we      <= 1'b0;
            l_sgn     <= 1'b0;
            l_size    <= SZ_B;
            l_off     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_err   <= ERR_OK;
        end else begin
            state     <= n_state;
            cnt       <= n_cnt;
            l_we      <= n_l_we;
            l_sgn     <= n_l_sgn;
            l_size    <= n_l_size;
            l_off     <= n_l_off;
            mem_req   <= n_mem_req;
            mem_we    <= n_mem_we;
            mem_addr  <= n_mem_addr;
            mem_wdata <= n_mem_wdata;
            mem_be    <= n_mem_be;
            rsp_valid <= n_rsp_valid;
            rsp_data  <= n_rsp_data;
            rsp_rd    <= n_rsp_rd;
            rsp_err   <= n_rsp_err;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit (32-bit and 64-bit builds).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err;

    logic        d_req_valid, d_req_ready, d_req_write, d_req_signed;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic [4:0]  d_req_rd;
    logic        d_mem_req, d_mem_we, d_mem_ack;
    logic [31:0] d_mem_addr;
    logic [63:0] d_mem_wdata, d_mem_rdata;
    logic [7:0]  d_mem_be;
    logic        d_rsp_valid, d_rsp_ready;
    logic [63:0] d_rsp_data;
    logic [4:0]  d_rsp_rd;
    logic [1:0]  d_rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    load_store_unit #(.DATA_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_write(d_req_write),
        .req_size(d_req_size), .req_signed(d_req_signed), .req_addr(d_req_addr),
        .req_wdata(d_req_wdata), .req_rd(d_req_rd),
        .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
        .mem_wdata(d_mem_wdata), .mem_be(d_mem_be), .mem_ack(d_mem_ack), .mem_rdata(d_mem_rdata),
        .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_data(d_rsp_data),
        .rsp_rd(d_rsp_rd), .rsp_err(d_rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 32-bit transaction. ack_at: cycle (1..15) after acceptance at which mem_ack pulses;
    // anything else means memory never answers. stall: cycles rsp_ready is held low.
    task automatic op(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input int ack_at,
                      input logic [31:0] rdat, input int stall);
        int nb, off, n, exp_n;
        logic [63:0] mask, lo, rep, ev;
        logic [3:0]  ebe;
        logic        mis, tmo;
        nb   = 1 << sz;
        off  = int'(a[1:0]);
        mis  = (sz == 2'b11) || (off % nb != 0);
        mask = (64'd1 << (8 * nb)) - 1;
        lo   = {32'd0, wd} & mask;
        rep  = 0;
        for (int k = 0; k < 4; k += nb) rep = rep | (lo << (8 * k));
        ebe  = 4'(((1 << nb) - 1) << off);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 0; req_write = $urandom; req_size = 2'($urandom); req_signed = $urandom;
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (mis) begin
            chk("misal_no_mem_req", {63'd0, mem_req}, 64'd0);
            chk("misal_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("misal_rsp_err", {62'd0, rsp_err}, 64'd1);
            chk("misal_rsp_data", {32'd0, rsp_data}, 64'd0);
            chk("misal_rsp_rd", {59'd0, rsp_rd}, {59'd0, rd});
        end else begin
            chk("mem_req", {63'd0, mem_req}, 64'd1);
            chk("mem_we", {63'd0, mem_we}, {63'd0, w});
            chk("mem_addr", {32'd0, mem_addr}, {32'd0, a[31:2], 2'b00});
            chk("mem_be", {60'd0, mem_be}, {60'd0, ebe});
            chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, rep[31:0]});
            tmo   = !(ack_at >= 1 && ack_at <= 15);
            exp_n = tmo ? 15 : ack_at;
            n = 0;
            while (mem_req === 1'b1 && n < 40) begin
                n++;
                if (n == ack_at) begin mem_ack = 1; mem_rdata = rdat; end
                else mem_rdata = $urandom;
                @(posedge clk); #1;
                mem_ack = 0;
                if (mem_req === 1'b1)
                    chk("mem_addr_stable", {32'd0, mem_addr}, {32'd0, a[31:2], 2'b00});
            end
            chk("mem_req_cycles", 64'(n), 64'(exp_n));
            ev = ({32'd0, rdat} >> (8 * off)) & mask;
            if (sg && ((ev >> (8 * nb - 1)) & 64'd1) != 0) ev = ev | ~mask;
            chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("rsp_err", {62'd0, rsp_err}, tmo ? 64'd2 : 64'd0);
            chk("rsp_data", {32'd0, rsp_data}, (w || tmo) ? 64'd0 : {32'd0, ev[31:0]});
            chk("rsp_rd", {59'd0, rsp_rd}, {59'd0, rd});
        end
        for (int s = 0; s < stall; s++) begin
            req_valid = 1; req_size = 2'b10; req_addr = 32'h40;
            @(posedge clk); #1;
            chk("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
            chk("stall_no_mem_req", {63'd0, mem_req}, 64'd0);
            chk("stall_rsp_rd", {59'd0, rsp_rd}, {59'd0, rd});
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("rsp_done", {63'd0, rsp_valid}, 64'd0);
        chk("ready_again", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic op64(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [63:0] rdat, input logic [7:0] ebe,
                        input logic [63:0] edata, input logic [1:0] eerr);
        d_req_valid = 1; d_req_write = 0; d_req_size = sz; d_req_signed = sg;
        d_req_addr = a; d_req_rd = 5'd9;
        @(posedge clk); #1;
        d_req_valid = 0;
        if (eerr == 2'b00) begin
            chk("d_mem_req", {63'd0, d_mem_req}, 64'd1);
            chk("d_mem_be", {56'd0, d_mem_be}, {56'd0, ebe});
            chk("d_mem_addr", {32'd0, d_mem_addr}, {32'd0, a[31:3], 3'b000});
            d_mem_ack = 1; d_mem_rdata = rdat;
            @(posedge clk); #1;
            d_mem_ack = 0;
        end else chk("d_misal_no_req", {63'd0, d_mem_req}, 64'd0);
        chk("d_rsp_valid", {63'd0, d_rsp_valid}, 64'd1);
        chk("d_rsp_err", {62'd0, d_rsp_err}, {62'd0, eerr});
        chk("d_rsp_data", d_rsp_data, edata);
        d_rsp_ready = 1;
        @(posedge clk); #1;
        d_rsp_ready = 0;
    endtask

    initial begin
        rst_n = 0;
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0; mem_ack = 0; mem_rdata = 0; rsp_ready = 0;
        d_req_valid = 0; d_req_write = 0; d_req_size = 0; d_req_signed = 0;
        d_req_addr = 0; d_req_wdata = 0; d_req_rd = 0; d_mem_ack = 0; d_mem_rdata = 0; d_rsp_ready = 0;
        #1;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mem_be", {60'd0, mem_be}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_err", {62'd0, rsp_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

        op(0, 2'b00, 1, 32'h103, 32'h0, 5'd3, 1, 32'h80FF_0000, 0);
        op(1, 2'b01, 0, 32'h202, 32'h0000_BEEF, 5'd4, 2, 32'h0, 0);
        op(0, 2'b10, 0, 32'h301, 32'h0, 5'd7, 1, 32'h0, 0);
        op(0, 2'b10, 0, 32'h400, 32'h0, 5'd8, 0, 32'h0, 0);
        op(0, 2'b10, 1, 32'h404, 32'h0, 5'd9, 15, 32'hDEAD_BEEF, 0);
        op(0, 2'b01, 1, 32'h10E, 32'h0, 5'd10, 3, 32'h8001_1234, 5);
        op(0, 2'b01, 0, 32'h10E, 32'h0, 5'd11, 1, 32'h8001_1234, 0);
        op(1, 2'b00, 0, 32'h501, 32'h1234_56A5, 5'd12, 1, 32'h0, 1);
        op(0, 2'b11, 0, 32'h600, 32'h0, 5'd13, 1, 32'h0, 0);

        for (int i = 0; i < 50; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int r, ack;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0 && sz == 2'b11) sz = 2'b10;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            r = $urandom_range(0, 9);
            ack = r < 7 ? $urandom_range(1, 4) : r == 7 ? 15 : r == 8 ? 0 : 14;
            op($urandom, sz, $urandom, a, $urandom, 5'($urandom), ack, $urandom, $urandom_range(0, 3));
        end

        req_valid = 1; req_write = 0; req_size = 2'b10; req_addr = 32'h40; req_rd = 5'd5;
        @(posedge clk); #1;
        req_valid = 0;
        chk("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_async_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_async_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk); #1 rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_ack_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("late_ack_req_ready", {63'd0, req_ready}, 64'd1);
        chk("late_ack_mem_req", {63'd0, mem_req}, 64'd0);

        op64(2'b11, 0, 32'h8, 64'h8123_4567_89AB_CDEF, 8'hFF, 64'h8123_4567_89AB_CDEF, 2'b00);
        op64(2'b10, 1, 32'hC, 64'h9000_0001_0000_0000, 8'hF0, 64'hFFFF_FFFF_9000_0001, 2'b00);
        op64(2'b10, 0, 32'hC, 64'h9000_0001_0000_0000, 8'hF0, 64'h0000_0000_9000_0001, 2'b00);
        op64(2'b00, 1, 32'hD, 64'h0000_8000_0000_0000, 8'h20, 64'hFFFF_FFFF_FFFF_FF80, 2'b00);
        op64(2'b11, 0, 32'h4, 64'h0, 8'h00, 64'h0, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
